// File: rtl/prog_loader.sv
// Front-panel loader: builds bytes from two switch nibbles, writes
// them to program memory, holds the CPU in reset until Run.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   insw[3:0]      switch nibble, sampled on Load presses
//   btn_load       raw Load button
//   btn_run        raw Run button
//   mem_addr[7:0]  write address, stable while mem_we is high
//   mem_din[7:0]   write data
//   mem_we         one-cycle write strobe per byte
//   cpu_rst        high while loading, low once in RUN
//   hi_phase       1 = next Load press takes the high nibble
//   count[3:0]     bytes written, saturating at DEPTH

module prog_loader_db #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          btn_s;
  logic          stable;
  logic [CW-1:0] cnt;

  // Fires on the edge where stable is about to rise.
  assign press = btn_s & ~stable & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      btn_s <= btn;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module prog_loader #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_BASE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] insw,
  input  logic       btn_load,
  input  logic       btn_run,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we,
  output logic       cpu_rst,
  output logic       hi_phase,
  output logic [3:0] count
);

  localparam logic [7:0] A_FIRST = 8'(ADDR_BASE);
  localparam logic [7:0] A_LAST  = 8'(ADDR_BASE + DEPTH - 1);
  // count is only 4 bits wide; clamp for large DEPTH.
  localparam logic [3:0] C_MAX   =
    (DEPTH > 15) ? 4'd15 : 4'(DEPTH);

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    WRITE,
    RUN
  } state_t;

  state_t     state;
  logic [3:0] hi_nib;
  logic       load_p;
  logic       run_p;

  prog_loader_db #(.N(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .press (load_p)
  );

  prog_loader_db #(.N(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_run),
    .press (run_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_HI;
      hi_nib   <= 4'h0;
      mem_addr <= A_FIRST;
      mem_din  <= 8'h00;
      mem_we   <= 1'b0;
      cpu_rst  <= 1'b1;
      hi_phase <= 1'b1;
      count    <= 4'h0;
    end else begin
      unique case (state)
        LOAD_HI: begin
          if (run_p) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else if (load_p) begin
            hi_nib   <= insw;
            hi_phase <= 1'b0;
            state    <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          // Run beats a simultaneous Load; pending nibble dropped.
          if (run_p) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else if (load_p) begin
            mem_din <= {hi_nib, insw};
            mem_we  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          hi_phase <= 1'b1;
          if (count != C_MAX) begin
            count <= count + 1'b1;
          end
          // Address advances only after the strobe cycle.
          if (mem_addr == A_LAST) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            mem_addr <= mem_addr + 8'd1;
            state    <= LOAD_HI;
          end
        end
        RUN: begin
          mem_we <= 1'b0;
        end
        default: begin
          state <= LOAD_HI;
        end
      endcase
    end
  end

endmodule
